mac_operand_feeder: RTL and testbench
=====================================

# mac_operand_feeder

Transmit-side driver for the multiply-accumulate unit. It holds a small operand buffer loaded by the host and, on `start`, clears the MAC and streams `len` signed 8-bit operand pairs into the MAC's `a`/`b`/`valid_in` inputs. It then waits out the MAC pipeline, captures the accumulated 16-bit result and overflow flag, and reports them with a one-cycle `done` pulse. It sits between the host/control logic and the MAC and owns the MAC's `reset` and input side.

## Interface
Parameters:
- `DEPTH`, 16: operand-pair buffer entries; power of two, ≥2.
- `MAC_LAT`, 8: cycles from the last `mac_valid_in` cycle until that pair's contribution is stable on `mac_f`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  $clog2(DEPTH)  buffer write address.
- `wr_a`, `wr_b`  in  8 signed  operand pair to write.
- `len`  in  $clog2(DEPTH)+1  pair count, 0..DEPTH; sampled with `start`.
- `start`  in  1  begin a dot product; honoured only in IDLE.
- `busy`  out  1  operation in progress.
- `mac_reset`  out  1  drives the MAC `reset`.
- `mac_a`, `mac_b`  out  8 signed  drive the MAC `a`/`b`.
- `mac_valid_in`  out  1  drives the MAC `valid_in`.
- `mac_f`  in  16 signed  MAC accumulator output.
- `mac_overflow`  in  1  MAC overflow flag.
- `result`  out  16 signed  captured dot product; holds until the next capture.
- `result_ovf`  out  1  overflow seen during the operation; holds with `result`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CLEAR, ISSUE, DRAIN, CAPTURE.
- **IDLE**
  - `busy`=0.
  - `wr_en` writes `{wr_a,wr_b}` to `mem[wr_addr]`. `wr_en` in any other state is ignored.
  - `start` with `len`=0: no MAC activity. `result`←0, `result_ovf`←0, `done`=1 next cycle. State stays IDLE.
  - `start` with `len`>`DEPTH`: treated as `len`=`DEPTH`.
  - `start` with `len`≥1: latch `len`, go to CLEAR.
- **CLEAR** (1 cycle)
  - `mac_reset`=1; clear the sticky overflow; `idx`←0; go to ISSUE.
- **ISSUE**
  - `mac_a`=`mem[idx].a`, `mac_b`=`mem[idx].b`, `mac_valid_in`=1.
  - `idx` increments each cycle. After the pair at `idx`=`len`-1, go to DRAIN with `cnt`←`MAC_LAT`.
- **DRAIN**
  - `mac_valid_in`=0, `mac_a`=`mac_b`=0.
  - `cnt` decrements each cycle; at `cnt`=1, go to CAPTURE.
- **CAPTURE** (1 cycle)
  - `result`←`mac_f`, `result_ovf`←sticky | `mac_overflow`.
  - Next cycle: `done`=1, state IDLE.
- Sticky overflow ORs `mac_overflow` every cycle in ISSUE (excluding the first ISSUE cycle) and in DRAIN.
- `start` while `busy` is ignored (not queued).
- Arithmetic is performed by the MAC. The feeder does no arithmetic beyond counters. `idx` ranges 0..DEPTH-1, and `len` never causes `idx` to wrap.

## Timing
- All outputs are registered, except `mac_reset`, which is `reset` | (state==CLEAR). The MAC is therefore cleared in the same cycle the feeder is reset.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled high in IDLE.
  - Cycle 1: `mac_reset`=1, `busy`=1.
  - Cycles 2..`len`+1: `mac_valid_in`=1, carrying pair k-2 in cycle k.
  - Cycles `len`+2..`len`+1+`MAC_LAT`: DRAIN, with CAPTURE on the last of these.
  - Cycle `len`+2+`MAC_LAT`: `done`=1, `busy`=0, `result` valid. A new `start` is accepted in this cycle.
- `len`=0: `done`=1 in cycle 1, `busy` never asserted.
- Reset values: `busy`, `mac_a`, `mac_b`, `mac_valid_in`, `result`, `result_ovf`, `done` all 0. `mac_reset`=1 while `reset` is high. The buffer contents are not reset.
- `reset` mid-operation: the next cycle is IDLE with all outputs at reset values and no `done`.

## Configuration
- `MAC_FEED_GAP_EN` defined:
  - ISSUE inserts one idle cycle (`mac_valid_in`=0, `mac_a`=`mac_b`=0) between consecutive pairs, exercising the MAC's valid gating.
  - The ISSUE phase lasts 2·`len`-1 cycles, so `done` arrives in cycle 2·`len`+1+`MAC_LAT`.
- `MAC_FEED_GAP_EN` not defined: back-to-back issue as specified above.

## Test plan
1. Load (1,1),(2,2),(3,3); `len`=3, `start` → `mac_reset` high in cycle 1; `mac_valid_in` high in cycles 2–4 with `mac_a`=1,2,3; `done` in cycle 13 (`MAC_LAT`=8); `result`=14, `result_ovf`=0.
2. `len`=0, `start` → `done` in cycle 1; `result`=0; `mac_valid_in` and `mac_reset` never asserted.
3. Load (127,127)×3; `len`=3 → true sum 48387 exceeds 32767; `result_ovf`=1.
4. Load (-128,127),(5,-3); `len`=2 → `result`=-16271, `result_ovf`=0.
5. Assert `reset` in cycle 3 of a `len`=4 run → `mac_reset`=1 that cycle; all outputs 0 and `busy`=0 next cycle; no `done`. A following `len`=1 run with (2,3) returns `result`=6.
6. During a run, pulse `start` and `wr_en` (addr 0, value (9,9)) → no restart; after `done`, a `len`=1 run returns the original `mem[0]` product. With `MAC_FEED_GAP_EN` defined, scenario 1 shows `mac_valid_in` high only in cycles 2, 4, 6, and `result`=14.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - operand-pair buffer and MAC issue sequencer; MAC_FEED_GAP_EN inserts an idle cycle between issued pairs
module mac_operand_feeder #(
  parameter int DEPTH   = 16,
  parameter int MAC_LAT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic signed [7:0]          wr_a,
  input  logic signed [7:0]          wr_b,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       start,
  output logic                       busy,
  output logic                       mac_reset,
  output logic signed [7:0]          mac_a,
  output logic signed [7:0]          mac_b,
  output logic                       mac_valid_in,
  input  logic signed [15:0]         mac_f,
  input  logic                       mac_overflow,
  output logic signed [15:0]         result,
  output logic                       result_ovf,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (MAC_LAT < 2) ? 2 : $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_CAPTURE} state_t;

  state_t          state, state_n;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   idx, idx_n;
  logic [AW-1:0]   last_idx, last_idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            gap, gap_n;
  logic            first_issue, first_issue_n;
  logic            sticky, sticky_n;
  logic            zero_start;
  logic            issue_n;
  logic [LW-1:0]   len_c;

  // The MAC is held in reset with the feeder and for the single CLEAR cycle.
  assign mac_reset = reset | (state == S_CLEAR);

  // Outputs are registered, so the next cycle's MAC drive is derived from the next state.
  assign issue_n = (state_n == S_ISSUE) && !gap_n;

  // Host writes land in the buffer only while idle; buffer contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE) mem[wr_addr] <= {wr_a, wr_b};
  end

  // Next-state, index, drain counter and sticky overflow.
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    last_idx_n    = last_idx;
    cnt_n         = cnt;
    gap_n         = gap;
    first_issue_n = first_issue;
    sticky_n      = sticky;
    zero_start    = 1'b0;
    len_c         = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            zero_start = 1'b1;
          end else begin
            last_idx_n = AW'(len_c - LW'(1));
            state_n    = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        sticky_n      = 1'b0;
        idx_n         = '0;
        gap_n         = 1'b0;
        first_issue_n = 1'b1;
        state_n       = S_ISSUE;
      end
      S_ISSUE: begin
        first_issue_n = 1'b0;
        // The MAC flag is still settling from CLEAR on the first issue cycle.
        if (!first_issue) sticky_n = sticky | mac_overflow;
        if (gap) begin
          gap_n = 1'b0;
        end else if (idx == last_idx) begin
          if (MAC_LAT < 2) begin
            state_n = S_CAPTURE;
          end else begin
            state_n = S_DRAIN;
            cnt_n   = CW'(MAC_LAT);
          end
        end else begin
          idx_n = idx + AW'(1);
`ifdef MAC_FEED_GAP_EN
          gap_n = 1'b1;
`else
          gap_n = 1'b0;
`endif
        end
      end
      S_DRAIN: begin
        sticky_n = sticky | mac_overflow;
        cnt_n    = cnt - CW'(1);
        // DRAIN plus CAPTURE together span MAC_LAT cycles.
        if (cnt == CW'(2)) state_n = S_CAPTURE;
      end
      S_CAPTURE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      last_idx     <= '0;
      cnt          <= '0;
      gap          <= 1'b0;
      first_issue  <= 1'b0;
      sticky       <= 1'b0;
      busy         <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      mac_valid_in <= 1'b0;
      result       <= '0;
      result_ovf   <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      last_idx     <= last_idx_n;
      cnt          <= cnt_n;
      gap          <= gap_n;
      first_issue  <= first_issue_n;
      sticky       <= sticky_n;
      busy         <= (state_n != S_IDLE);
      mac_valid_in <= issue_n;
      mac_a        <= issue_n ? $signed(mem[idx_n][15:8]) : 8'sd0;
      mac_b        <= issue_n ? $signed(mem[idx_n][7:0])  : 8'sd0;
      done         <= (state == S_CAPTURE) | zero_start;
      if (state == S_CAPTURE) begin
        result     <= mac_f;
        result_ovf <= sticky | mac_overflow;
      end else if (zero_start) begin
        result     <= '0;
        result_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - directed table-driven bench for mac_operand_feeder with a behavioural MAC
module tb_mac_operand_feeder;

  localparam int DEPTH   = 16;
  localparam int MAC_LAT = 8;
`ifdef MAC_FEED_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               wr_en;
  logic [3:0]         wr_addr;
  logic signed [7:0]  wr_a, wr_b;
  logic [4:0]         len;
  logic               start;
  logic               busy;
  logic               mac_reset;
  logic signed [7:0]  mac_a, mac_b;
  logic               mac_valid_in;
  logic signed [15:0] mac_f;
  logic               mac_overflow;
  logic signed [15:0] result;
  logic               result_ovf;
  logic               done;

  int checks = 0;
  int failures = 0;

  logic signed [7:0] ea [DEPTH];
  logic signed [7:0] eb [DEPTH];

  always #5 clk = ~clk;

  mac_operand_feeder #(.DEPTH(DEPTH), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .len(len), .start(start), .busy(busy), .mac_reset(mac_reset), .mac_a(mac_a), .mac_b(mac_b),
    .mac_valid_in(mac_valid_in), .mac_f(mac_f), .mac_overflow(mac_overflow),
    .result(result), .result_ovf(result_ovf), .done(done)
  );

  // Behavioural MAC: 16-bit wrapping accumulator, sticky overflow, 4-stage output pipe.
  logic signed [15:0] acc;
  logic               acc_ovf;
  logic signed [15:0] pf [4];
  logic               po [4];
  always @(posedge clk) begin : mac_model
    int s;
    if (mac_reset) begin
      acc <= '0;
      acc_ovf <= 1'b0;
      for (int i = 0; i < 4; i++) begin pf[i] <= '0; po[i] <= 1'b0; end
    end else begin
      if (mac_valid_in) begin
        s = int'(acc) + int'(mac_a) * int'(mac_b);
        acc <= 16'(s);
        acc_ovf <= acc_ovf | (s > 32767) | (s < -32768);
      end
      pf[0] <= acc;
      po[0] <= acc_ovf;
      for (int i = 1; i < 4; i++) begin pf[i] <= pf[i-1]; po[i] <= po[i-1]; end
    end
  end
  assign mac_f = pf[3];
  assign mac_overflow = po[3];

  typedef struct packed {
    logic [4:0]       len;
    logic [2:0]       npairs;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [15:0]      exp_res;
    logic             chk_res;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input int addr, input int a, input int b);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_a = 8'(a); wr_b = 8'(b);
    ea[addr] = 8'(a); eb[addr] = 8'(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic run_op(input int l, input int eff, input longint exp_res, input bit chk_res,
                        input bit exp_ovf, input string nm, input int inj);
    int done_cyc, exp_done, nvalid, seq_bad, busy_bad, rst_bad;
    done_cyc = -1; nvalid = 0; seq_bad = 0; busy_bad = 0; rst_bad = 0;
    exp_done = (eff == 0) ? 1 : (GAP ? 2*eff + 1 + MAC_LAT : eff + 2 + MAC_LAT);
    len = 5'(l); start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      int p;
      if (mac_reset != (c == 1 && eff > 0)) rst_bad++;
      if (busy != (c < exp_done)) busy_bad++;
      if (mac_valid_in) begin
        nvalid++;
        p = GAP ? (c - 2) / 2 : c - 2;
        if ((GAP && (c % 2) != 0) || p < 0 || p >= eff) seq_bad++;
        else if (mac_a != ea[p] || mac_b != eb[p]) seq_bad++;
      end else if (mac_a != 0 || mac_b != 0) seq_bad++;
      if (done) done_cyc = c;
      else begin
        if (c == inj) begin
          start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_a = 8'sd9; wr_b = 8'sd9;
        end
        step();
        start = 1'b0; wr_en = 1'b0;
      end
    end
    chk({nm, " done_cycle"}, done_cyc, exp_done);
    chk({nm, " valid_count"}, nvalid, eff);
    chk({nm, " issue_seq_errors"}, seq_bad, 0);
    chk({nm, " busy_errors"}, busy_bad, 0);
    chk({nm, " mac_reset_errors"}, rst_bad, 0);
    if (chk_res) chk({nm, " result"}, result, exp_res);
    chk({nm, " result_ovf"}, result_ovf, exp_ovf);
    if (done_cyc > 0) begin
      step();
      chk({nm, " done_pulse_width"}, done, 0);
      chk({nm, " result_ovf_hold"}, result_ovf, exp_ovf);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0; len = '0; start = 1'b0;

    vecs[0] = '{len: 5'd3, npairs: 3'd3, a: {8'd0, 8'd3, 8'd2, 8'd1}, b: {8'd0, 8'd3, 8'd2, 8'd1},
                exp_res: 16'd14, chk_res: 1'b1, exp_ovf: 1'b0};
    vecs[1] = '{len: 5'd0, npairs: 3'd0, a: '0, b: '0,
                exp_res: 16'd0, chk_res: 1'b1, exp_ovf: 1'b0};
    vecs[2] = '{len: 5'd3, npairs: 3'd3, a: {8'd0, 8'd127, 8'd127, 8'd127}, b: {8'd0, 8'd127, 8'd127, 8'd127},
                exp_res: 16'd0, chk_res: 1'b0, exp_ovf: 1'b1};
    vecs[3] = '{len: 5'd2, npairs: 3'd2, a: {8'd0, 8'd0, 8'd5, 8'h80}, b: {8'd0, 8'd0, 8'hFD, 8'd127},
                exp_res: 16'hC071, chk_res: 1'b1, exp_ovf: 1'b0};

    repeat (2) step();
    chk("mac_reset_during_reset", mac_reset, 1);
    chk("reset_busy", busy, 0);
    chk("reset_valid", mac_valid_in, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    reset = 1'b0;
    step();
    chk("idle_mac_reset", mac_reset, 0);

    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < int'(vecs[i].npairs); p++)
        load(p, int'($signed(vecs[i].a[p])), int'($signed(vecs[i].b[p])));
      run_op(int'(vecs[i].len), int'(vecs[i].len), longint'($signed(vecs[i].exp_res)),
             vecs[i].chk_res, vecs[i].exp_ovf, $sformatf("vec%0d", i), 0);
    end

    // Full buffer and oversized len: both clamp to DEPTH pairs, sum 0+1+...+15.
    for (int p = 0; p < DEPTH; p++) load(p, 1, p);
    run_op(16, 16, 120, 1'b1, 1'b0, "len_depth", 0);
    run_op(31, 16, 120, 1'b1, 1'b0, "len_clamp", 0);

    // Reset in cycle 3 of a len=4 run.
    for (int p = 0; p < 4; p++) load(p, p + 1, 2);
    len = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("midrun_mac_reset", mac_reset, 1);
    step();
    reset = 1'b0;
    chk("after_reset_busy", busy, 0);
    chk("after_reset_valid", mac_valid_in, 0);
    chk("after_reset_a", mac_a, 0);
    chk("after_reset_result", result, 0);
    chk("after_reset_done", done, 0);
    begin
      int seen = 0;
      for (int c = 0; c < 16; c++) begin
        if (done || busy) seen++;
        step();
      end
      chk("after_reset_no_done", seen, 0);
    end
    load(0, 2, 3);
    run_op(1, 1, 6, 1'b1, 1'b0, "post_reset", 0);

    // start and wr_en during a run are ignored.
    load(1, 4, 5);
    run_op(2, 2, 26, 1'b1, 1'b0, "inject", 3);
    run_op(1, 1, 6, 1'b1, 1'b0, "mem0_kept", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
